ps2_rx_decoder: RTL

PS2_RX_DECODER -- requirements
Module: ps2_rx_decoder

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_rx_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receive path: prefix bytes,
// frame FSM encoding and the layout of the decoded key event word.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int EXT_BIT = 9;
  localparam int BRK_BIT = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // A frame is good when the stop bit is high and data plus parity hold an odd number of ones.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity, input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the clk domain and flags
// each falling edge of the synchronized PS/2 clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  // Flops come out of reset at 1, matching an idle bus, so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign data_s = data_sync_q;
  assign fall   = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: assembles 11-bit frames, folds E0/F0 prefixes into
// flags and emits {ext, brk, code} key events with a one-cycle ready pulse.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] ps2_out,
  output logic       ready,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  logic data_s, fall;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    out_q, out_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  ps2_sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    tmo_d     = tmo_q;
    out_d     = out_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (frame_ok(shift_q, parity_q, data_s)) begin
            if (shift_q == PS2_EXT_PREFIX) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK_PREFIX) begin
              brk_d = 1'b1;
            end else begin
              out_d[EXT_BIT] = ext_q;
              out_d[BRK_BIT] = brk_q;
              out_d[7:0]     = shift_q;
              ready_d        = 1'b1;
              ext_d          = 1'b0;
              brk_d          = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled partial frame is abandoned silently; in IDLE the counter just holds.
      if (tmo_q == TMO_MAX) begin
        state_d = ST_IDLE;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      out_q     <= 10'h000;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      tmo_q     <= tmo_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign ps2_out   = out_q;
  assign ready     = ready_q;
  assign frame_err = err_q;

endmodule
